// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions. These are the payload bundle, its default
// width, and a constant log2 helper for sizing pointers.
package pipe_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  ctrl;
    } pipe_payload_t;

    localparam int PIPE_WIDTH = $bits(pipe_payload_t);

endpackage

// File: rtl/pipe_ring_mem.sv
// DEPTH x WIDTH register array for the stage buffer.
// It has one write port and one asynchronous read port.
module pipe_ring_mem
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 2,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset. Occupancy lives in the pointer/count logic,
    // so a stale entry is never observable and the array stays plain flops.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register built on a DEPTH-entry ring. It has a valid/ready handshake,
// a synchronous flush for redirects, and a saturating count of flushed entries.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 2,
    parameter  int CNT_W  = 16,
    localparam int PTR_W  = clog2(DEPTH),
    localparam int OCC_W  = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    input  logic             flush_i,
    output logic [OCC_W-1:0] count_o,
    output logic [CNT_W-1:0] discard_cnt_o
);

    localparam int               SUM_W   = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pipe_stage_buf: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;

    logic             push;
    logic             pop;
    logic [OCC_W-1:0] kill;
    logic [SUM_W-1:0] sat_sum;
    logic [WIDTH-1:0] rd_data;

    assign in_ready_o  = (count_q != OCC_FULL);
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? rd_data : '0;
    assign count_o       = count_q;
    assign discard_cnt_o = discard_cnt_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    // An entry popped in the flush cycle was delivered, so it is not a discard.
    assign kill    = count_q - OCC_W'(pop);
    assign sat_sum = SUM_W'(discard_cnt_q) + SUM_W'(kill);

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        discard_cnt_d = discard_cnt_q;
        if (flush_i) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            discard_cnt_d = (sat_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sat_sum[CNT_W-1:0];
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            discard_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    pipe_ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (push & ~flush_i),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_i)
        count_q <= OCC_FULL);
    a_valid_occ : assert property (@(posedge clk_i) disable iff (!rst_i)
        out_valid_o |-> (count_q != '0));
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_i)
        (count_q == OCC_FULL) |-> !push);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf. It uses a DEPTH=2 instance for the handshake and
// flush cases, and a DEPTH=4/CNT_W=2 instance for discard-counter saturation.
module tb_pipe_stage_buf;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;

    logic        in_valid_i = 1'b0;
    logic [31:0] in_data_i  = '0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_ready_i = 1'b0;
    logic        flush_i     = 1'b0;
    logic [1:0]  count_o;
    logic [15:0] discard_cnt_o;

    logic        s_in_valid  = 1'b0;
    logic [31:0] s_in_data   = '0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_out_ready = 1'b0;
    logic        s_flush     = 1'b0;
    logic [2:0]  s_count;
    logic [1:0]  s_discard;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_ready_i   (out_ready_i),
        .flush_i       (flush_i),
        .count_o       (count_o),
        .discard_cnt_o (discard_cnt_o)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) u_sat (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (s_in_valid),
        .in_data_i     (s_in_data),
        .in_ready_o    (s_in_ready),
        .out_valid_o   (s_out_valid),
        .out_data_o    (s_out_data),
        .out_ready_i   (s_out_ready),
        .flush_i       (s_flush),
        .count_o       (s_count),
        .discard_cnt_o (s_discard)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_data", 64'(out_data_o), 64'd0);
        check("rst_disc", 64'(discard_cnt_o), 64'd0);
        #10 rst_i = 1'b1;
        step();

        // Single transfer, latency 1, no bypass
        in_valid_i  = 1'b1;
        in_data_i   = 32'hA5A5_0001;
        out_ready_i = 1'b1;
        #1;
        check("nobypass_valid", 64'(out_valid_o), 64'd0);
        step();
        in_valid_i = 1'b0;
        check("first_valid", 64'(out_valid_o), 64'd1);
        check("first_data", 64'(out_data_o), 64'hA5A5_0001);
        check("first_count", 64'(count_o), 64'd1);
        step();
        check("first_drain_count", 64'(count_o), 64'd0);
        check("first_drain_valid", 64'(out_valid_o), 64'd0);
        check("empty_data_gated", 64'(out_data_o), 64'd0);

        // Streaming at full throughput
        out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'h10 + 32'(i);
            #1;
            check("stream_ready", 64'(in_ready_o), 64'd1);
            step();
            check("stream_data", 64'(out_data_o), 64'(32'h10 + 32'(i)));
            check("stream_count", 64'(count_o), 64'd1);
        end
        in_valid_i = 1'b0;
        step();
        check("stream_end_count", 64'(count_o), 64'd0);

        // Fill and back-pressure
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h1;
        step();
        check("fill1_count", 64'(count_o), 64'd1);
        check("fill1_ready", 64'(in_ready_o), 64'd1);
        in_data_i = 32'h2;
        step();
        check("fill2_count", 64'(count_o), 64'd2);
        check("fill2_ready", 64'(in_ready_o), 64'd0);
        in_data_i = 32'h3;
        step();
        check("held_count", 64'(count_o), 64'd2);
        check("held_ready", 64'(in_ready_o), 64'd0);
        check("held_head", 64'(out_data_o), 64'h1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("pop_full_count", 64'(count_o), 64'd1);
        check("pop_full_ready", 64'(in_ready_o), 64'd1);
        check("order_2", 64'(out_data_o), 64'h2);
        step();
        in_valid_i = 1'b0;
        check("accept3_count", 64'(count_o), 64'd2);
        out_ready_i = 1'b1;
        step();
        check("order_3", 64'(out_data_o), 64'h3);
        check("order_3_count", 64'(count_o), 64'd1);
        step();
        check("fill_drain_count", 64'(count_o), 64'd0);

        // Flush a full buffer with an attempted push of 0x9
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h7;
        step();
        in_data_i = 32'h8;
        step();
        check("preflush_count", 64'(count_o), 64'd2);
        in_data_i = 32'h9;
        flush_i   = 1'b1;
        step();
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_disc", 64'(discard_cnt_o), 64'd2);
        // Consecutive flush on an empty buffer
        in_valid_i = 1'b0;
        step();
        check("flush_empty_disc", 64'(discard_cnt_o), 64'd2);
        flush_i = 1'b0;
        step();
        check("no_0x9_valid", 64'(out_valid_o), 64'd0);

        // Flush with a same-cycle pop (not discarded) and dropped push
        in_valid_i = 1'b1;
        in_data_i  = 32'hA;
        step();
        check("popflush_pre", 64'(count_o), 64'd1);
        in_data_i   = 32'hB;
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("popflush_disc", 64'(discard_cnt_o), 64'd2);
        check("popflush_count", 64'(count_o), 64'd0);
        step();
        check("popflush_no_b", 64'(out_valid_o), 64'd0);

        // Saturation on the DEPTH=4, CNT_W=2 instance
        s_in_valid = 1'b1;
        s_in_data  = 32'h55;
        step();
        s_in_valid = 1'b0;
        s_flush    = 1'b1;
        step();
        s_flush = 1'b0;
        check("sat_partial", 64'(s_discard), 64'd1);
        for (int f = 0; f < 3; f++) begin
            s_in_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                s_in_data = 32'h100 + 32'(k);
                step();
            end
            s_in_valid = 1'b0;
            check("sat_full_count", 64'(s_count), 64'd4);
            check("sat_full_ready", 64'(s_in_ready), 64'd0);
            s_flush = 1'b1;
            step();
            s_flush = 1'b0;
            check("sat_disc", 64'(s_discard), 64'd3);
            check("sat_empty", 64'(s_out_valid), 64'd0);
        end

        // Asynchronous reset mid-stream with count=1
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hC;
        step();
        in_valid_i = 1'b0;
        check("prereset_count", 64'(count_o), 64'd1);
        #2 rst_i = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid_o), 64'd0);
        check("arst_ready", 64'(in_ready_o), 64'd1);
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_disc", 64'(discard_cnt_o), 64'd0);
        check("arst_sat_disc", 64'(s_discard), 64'd0);
        #3 rst_i = 1'b1;
        out_ready_i = 1'b1;
        step();
        check("post_rst_valid", 64'(out_valid_o), 64'd0);
        check("post_rst_count", 64'(count_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
